sort_serializer: RTL and testbench
==================================

SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, words per frame; a power of two, at least 1.
REQ-002 SHALL have parameter WIDTH, default 32, bits per word.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port valid_in, input, 1, a parallel frame is offered on seq_in.
REQ-006 SHALL have port seq_in, input, DEPTH x WIDTH unpacked array [0:DEPTH-1], the parallel frame with element 0 first.
REQ-007 SHALL have port in_ready, output, 1, the block can capture a frame this cycle.
REQ-008 SHALL have port reverse, input, 1, emit order select, sampled with the frame: 0 emits index 0 first, 1 emits index DEPTH-1 first.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a valid word.
REQ-010 SHALL have port out_data, output, WIDTH, the current serial word.
REQ-011 SHALL have port out_last, output, 1, the current word is the final word of the frame.
REQ-012 SHALL have port out_ready, input, 1, the downstream sink accepts the word.
REQ-013 SHALL have port overrun, output, 1, sticky flag: a frame was offered while in_ready was low.

Function
REQ-014 SHALL implement an FSM with states IDLE and STREAM.
REQ-015 SHALL drive in_ready=1 exactly in IDLE.
REQ-016 SHALL, in IDLE with valid_in=1, capture all of seq_in into an internal buffer, latch reverse, load index 0 (or DEPTH-1 if reverse), and go to STREAM.
REQ-017 SHALL drive out_valid=1 in STREAM only; the first word appears in the cycle after capture, giving 1-cycle latency.
REQ-018 SHALL drive out_data=buffer[index] and out_last=1 when the index is the final index (DEPTH-1 forward, 0 reverse).
REQ-019 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL advance the index by +1 (forward) or -1 (reverse) on each beat with out_valid and out_ready both high, without modular wrap.
REQ-021 SHALL return to IDLE on the beat accepting out_last; in_ready rises the following cycle, with no same-cycle recapture.
REQ-022 SHALL, when DEPTH=1, assert out_last on the single word; reverse has no effect.
REQ-023 SHALL, when valid_in=1 and in_ready=0, ignore the frame, leave the buffer unchanged, and set overrun; overrun clears only on rst.
REQ-024 SHALL, with out_ready held at 1, emit one frame in exactly DEPTH cycles; frame-to-frame throughput is DEPTH+1 cycles.
REQ-025 SHALL size the index register as max(1, $clog2(DEPTH)) bits.
REQ-026 SHALL drive out_data='0 whenever out_valid=0.

Reset
REQ-027 SHALL, on rst assertion at any time including mid-frame, immediately force: state=IDLE, in_ready=1 after release, out_valid=0, out_last=0, out_data='0, overrun=0, index=0, buffer cleared to '0.
REQ-028 SHALL discard any partially emitted frame on reset, with no further words of that frame emitted.

Structure
REQ-029 SHALL place the state enum (IDLE, STREAM) in shared package sort_pkg, alongside the default DEPTH/WIDTH constants used by the sort blocks.
REQ-030 SHALL be a single module; no sub-module is warranted.

Verification
REQ-031 SHALL cover forward order: DEPTH=8, seq_in={1..8}, reverse=0, out_ready=1 -> out_data 1,2,...,8 on consecutive cycles starting 1 cycle after capture; out_last only with 8.
REQ-032 SHALL cover reverse order: same frame, reverse=1 -> out_data 8,7,...,1; out_last with 1.
REQ-033 SHALL cover backpressure: out_ready toggling 1,0,0,1,... -> no word lost or duplicated; out_data stable during stalls; all 8 words delivered in order.
REQ-034 SHALL cover overrun: second frame offered mid-stream -> ignored, overrun=1 and stays 1, first frame output unchanged; next frame after IDLE is captured normally.
REQ-035 SHALL cover reset mid-frame: rst asserted after word 3 of 8 -> out_valid=0 immediately, in_ready=1 after release, next frame emitted from its first word.
REQ-036 SHALL cover DEPTH=1: seq_in={0xDEADBEEF} -> single beat 0xDEADBEEF with out_last=1, then IDLE.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the sort blocks: default frame geometry and the serializer state encoding.
package sort_pkg;
    localparam int SORT_DEPTH = 8;
    localparam int SORT_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sort_state_t;
endpackage

// File: rtl/sort_serializer_if.sv
// Frame-in / word-out bundle of the sort serializer; master drives the frame and the sink ready.
interface sort_serializer_if #(
    parameter int DEPTH = sort_pkg::SORT_DEPTH,
    parameter int WIDTH = sort_pkg::SORT_WIDTH
);
    logic             valid_in;
    logic [WIDTH-1:0] seq_in [0:DEPTH-1];
    logic             reverse;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             overrun;

    modport master (
        output valid_in, seq_in, reverse, out_ready,
        input  in_ready, out_valid, out_data, out_last, overrun
    );

    modport slave (
        input  valid_in, seq_in, reverse, out_ready,
        output in_ready, out_valid, out_data, out_last, overrun
    );
endinterface

// File: rtl/sort_serializer.sv
// Captures a DEPTH-word frame in one cycle and streams it word by word, first word 1 cycle after capture.
// Output holds while out_ready=0; a frame offered while busy is dropped and flagged in sticky overrun.
module sort_serializer
    import sort_pkg::*;
#(
    parameter int DEPTH = SORT_DEPTH,
    parameter int WIDTH = SORT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    sort_serializer_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_FWD = IW'(DEPTH - 1);

    sort_state_t      r_state;
    sort_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic             r_rev;
    logic             r_overrun;
    logic             w_idle;
    logic             w_beat;
    logic             w_is_last;

    assign w_idle    = (r_state == IDLE);
    assign w_beat    = (r_state == STREAM) && bus.out_ready;
    // Final index depends on the direction latched with the frame, not the live input.
    assign w_is_last = r_rev ? (r_idx == '0) : (r_idx == LAST_FWD);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (bus.valid_in) begin
                    w_state_nxt = STREAM;
                    w_idx_nxt   = bus.reverse ? LAST_FWD : '0;
                end
            end
            STREAM: begin
                if (w_beat) begin
                    if (w_is_last) begin
                        w_state_nxt = IDLE;
                    end else if (r_rev) begin
                        w_idx_nxt = r_idx - 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_rev     <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_idle && bus.valid_in) begin
                r_rev <= bus.reverse;
                for (int i = 0; i < DEPTH; i++) begin
                    r_buf[i] <= bus.seq_in[i];
                end
            end
            if (bus.valid_in && !w_idle) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = !w_idle;
    assign bus.out_data  = w_idle ? '0 : r_buf[r_idx];
    assign bus.out_last  = !w_idle && w_is_last;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_sort_serializer.sv
// Scoreboard bench: a queue-based frame model predicts each serial word; independent monitors pop and compare.
module tb_sort_serializer;
    typedef logic [31:0] frame8_t [8];
    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sort_serializer_if #(.DEPTH(8), .WIDTH(32)) bus8 ();
    sort_serializer_if #(.DEPTH(1), .WIDTH(32)) bus1 ();

    sort_serializer #(.DEPTH(8), .WIDTH(32)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    sort_serializer #(.DEPTH(1), .WIDTH(32)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    exp_t exp_q [$];
    exp_t q1 [$];
    logic exp_overrun = 1'b0;
    int   ready_mode  = 0;
    int   rdy_cnt     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Sink ready: always, fixed 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (ready_mode)
            0:       bus8.out_ready = 1'b1;
            1:       bus8.out_ready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
            default: bus8.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("overrun_flag", 64'(bus8.overrun), 64'(exp_overrun));
            if (bus8.out_valid) begin
                if (prev_stall) begin
                    check("stall_data", 64'(bus8.out_data), 64'(prev_data));
                    check("stall_last", 64'(bus8.out_last), 64'(prev_last));
                end
                if (bus8.out_ready) begin
                    if (exp_q.size() == 0) begin
                        timeout("unexpected_word");
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", 64'(bus8.out_data), 64'(e.d));
                        check("word_last", 64'(bus8.out_last), 64'(e.l));
                        n_pops++;
                    end
                end
                prev_stall = !bus8.out_ready;
                prev_data  = bus8.out_data;
                prev_last  = bus8.out_last;
            end else begin
                check("idle_data_zero", 64'(bus8.out_data), 64'd0);
                check("idle_last_zero", 64'(bus8.out_last), 64'd0);
                prev_stall = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                timeout("d1_unexpected_word");
            end else begin
                e = q1.pop_front();
                check("d1_data", 64'(bus1.out_data), 64'(e.d));
                check("d1_last", 64'(bus1.out_last), 64'(e.l));
            end
        end
    end

    task automatic wait_ready8();
        int t = 0;
        @(negedge clk);
        while (!bus8.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus8.in_ready) timeout("in_ready_wait");
    endtask

    // Model: words leave in index order (or reversed); the last one emitted carries last.
    task automatic send8(input frame8_t f, input logic rev);
        exp_t e;
        int   idx;
        wait_ready8();
        check("idle_model_empty", 64'(exp_q.size()), 64'd0);
        bus8.valid_in = 1'b1;
        bus8.reverse  = rev;
        for (int i = 0; i < 8; i++) bus8.seq_in[i] = f[i];
        @(posedge clk);
        #1;
        bus8.valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = rev ? 7 - k : k;
            e.d = f[idx];
            e.l = (k == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain8();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) timeout("drain");
    endtask

    task automatic rand_frame(output frame8_t f);
        for (int i = 0; i < 8; i++) f[i] = $urandom;
    endtask

    task automatic send1(input logic [31:0] w, input logic rev);
        exp_t e;
        @(negedge clk);
        check("d1_in_ready", 64'(bus1.in_ready), 64'd1);
        bus1.valid_in  = 1'b1;
        bus1.reverse   = rev;
        bus1.seq_in[0] = w;
        @(posedge clk);
        #1;
        bus1.valid_in = 1'b0;
        e.d = w;
        e.l = 1'b1;
        q1.push_back(e);
        @(negedge clk);
        check("d1_first_beat", 64'(bus1.out_valid), 64'd1);
        @(negedge clk);
        check("d1_back_idle", 64'(bus1.in_ready), 64'd1);
        check("d1_valid_low", 64'(bus1.out_valid), 64'd0);
        check("d1_drained", 64'(q1.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        frame8_t f;
        frame8_t g;
        int      base;
        int      t;

        bus8.valid_in = 1'b0;
        bus8.reverse  = 1'b0;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus8.seq_in[i] = '0;
        bus1.valid_in  = 1'b0;
        bus1.reverse   = 1'b0;
        bus1.out_ready = 1'b1;
        bus1.seq_in[0] = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_out_data", 64'(bus8.out_data), 64'd0);
        check("rst_out_last", 64'(bus8.out_last), 64'd0);
        check("rst_overrun", 64'(bus8.overrun), 64'd0);
        check("rst_d1_valid", 64'(bus1.out_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Forward 1..8, full throughput: 8 consecutive beats, idle again on the 9th cycle.
        for (int i = 0; i < 8; i++) f[i] = 32'(i + 1);
        send8(f, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fwd_stream_valid", 64'(bus8.out_valid), 64'd1);
        end
        @(negedge clk);
        check("fwd_idle_after", 64'(bus8.in_ready), 64'd1);
        drain8();

        send8(f, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rev_stream_valid", 64'(bus8.out_valid), 64'd1);
        end
        drain8();

        ready_mode = 1;
        rand_frame(f);
        send8(f, 1'b0);
        drain8();
        rand_frame(f);
        send8(f, 1'b1);
        drain8();
        ready_mode = 0;

        // Overrun: second frame offered two beats into the first is dropped.
        rand_frame(f);
        rand_frame(g);
        send8(f, 1'b0);
        repeat (2) @(negedge clk);
        check("busy_in_ready", 64'(bus8.in_ready), 64'd0);
        bus8.valid_in = 1'b1;
        bus8.reverse  = 1'b1;
        for (int i = 0; i < 8; i++) bus8.seq_in[i] = g[i];
        @(posedge clk);
        #1;
        bus8.valid_in = 1'b0;
        exp_overrun = 1'b1;
        drain8();
        send8(g, 1'b1);
        drain8();

        // Reset after word 3: rest of the frame is discarded.
        rand_frame(f);
        base = n_pops;
        send8(f, 1'b0);
        t = 0;
        while (n_pops < base + 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (n_pops < base + 3) timeout("pops_wait");
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        exp_overrun = 1'b0;
        #1;
        check("midrst_valid", 64'(bus8.out_valid), 64'd0);
        check("midrst_data", 64'(bus8.out_data), 64'd0);
        check("midrst_overrun", 64'(bus8.overrun), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus8.in_ready), 64'd1);
        rand_frame(f);
        send8(f, 1'b0);
        drain8();

        ready_mode = 2;
        for (int n = 0; n < 20; n++) begin
            rand_frame(f);
            send8(f, 1'($urandom_range(0, 1)));
        end
        drain8();
        ready_mode = 0;

        send1(32'hDEADBEEF, 1'b0);
        send1(32'h0BADF00D, 1'b1);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
